// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and widths for the per-stage pipeline registers.
// Bundle offsets are LSB-based bit positions within the packed ctrl/data vectors.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   localparam int IF_ID_CTRL_W  = 1;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 11;
   localparam int ID_EX_DATA_W  = 122;
   localparam int EX_MEM_CTRL_W = 5;
   localparam int EX_MEM_DATA_W = 70;
   localparam int MEM_WB_CTRL_W = 2;
   localparam int MEM_WB_DATA_W = 69;

   // ID/EX control bundle: {RegWrite, MemtoReg, MemRead, MemWrite, BranchEQ, ALUOp[3:0], ALUSrc, RegDst}
   localparam int ID_EX_REG_DST   = 0;
   localparam int ID_EX_ALU_SRC   = 1;
   localparam int ID_EX_ALU_OP    = 2;
   localparam int ID_EX_BRANCH_EQ = 6;
   localparam int ID_EX_MEM_WRITE = 7;
   localparam int ID_EX_MEM_READ  = 8;
   localparam int ID_EX_MEM_TO_REG = 9;
   localparam int ID_EX_REG_WRITE = 10;

   // ID/EX data bundle: {imm32, funct6, rd1, rd2, rt, rd, rs, shamt}
   localparam int ID_EX_SHAMT = 0;
   localparam int ID_EX_RS    = 5;
   localparam int ID_EX_RD    = 10;
   localparam int ID_EX_RT    = 15;
   localparam int ID_EX_RD2   = 20;
   localparam int ID_EX_RD1   = 52;
   localparam int ID_EX_FUNCT = 84;
   localparam int ID_EX_IMM   = 90;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream and downstream handshake bundle of one pipeline stage.
// A transfer happens on a rising edge where valid && ready; either side may change its signals otherwise.
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int CTRL_W = ID_EX_CTRL_W,
   parameter int DATA_W = ID_EX_DATA_W
);
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_ctrl, in_data, out_ready,
      input  in_ready, out_valid, out_ctrl, out_data
   );

   modport slave (
      input  in_valid, in_ctrl, in_data, out_ready,
      output in_ready, out_valid, out_ctrl, out_data
   );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Counter that advances by one per enabled cycle and holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register: one or two held entries behind a valid/ready handshake,
// synchronous flush of the control bits, and stall/bubble performance counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W              = ID_EX_CTRL_W,
   parameter int DATA_W              = ID_EX_DATA_W,
   parameter int SKID                = 1,
   parameter int CLEAR_DATA_ON_FLUSH = 0,
   parameter int CNT_W               = 16
) (
   input  logic             clk,
   input  logic             reset,
   pipe_stage_reg_if.slave  bus,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] bubble_count,
   output pipe_state_e      state_dbg
);
   pipe_state_e       state, next_state;
   logic              ready_q, in_ready_q, in_ready_w;
   logic              out_valid_w, in_fire, out_fire;
   logic [CTRL_W-1:0] main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
   logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;

   assign out_valid_w = (state != EMPTY);
   // With the skid entry, in_ready is a flop so it never depends on out_ready this cycle.
   assign in_ready_w  = (SKID != 0) ? in_ready_q
                                    : (ready_q && (!out_valid_w || bus.out_ready));
   assign in_fire     = bus.in_valid && in_ready_w;
   assign out_fire    = out_valid_w && bus.out_ready;

   always_comb begin
      next_state  = state;
      main_ctrl_n = main_ctrl;
      main_data_n = main_data;
      skid_ctrl_n = skid_ctrl;
      skid_data_n = skid_data;
      if (flush) begin
         next_state  = EMPTY;
         main_ctrl_n = '0;
         skid_ctrl_n = '0;
         if (CLEAR_DATA_ON_FLUSH != 0) begin
            main_data_n = '0;
            skid_data_n = '0;
         end
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  next_state  = ONE;
                  main_ctrl_n = bus.in_ctrl;
                  main_data_n = bus.in_data;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_ctrl_n = bus.in_ctrl;
                  main_data_n = bus.in_data;
               end else if (in_fire) begin
                  next_state  = TWO;
                  skid_ctrl_n = bus.in_ctrl;
                  skid_data_n = bus.in_data;
               end else if (out_fire) begin
                  next_state = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  next_state  = ONE;
                  main_ctrl_n = skid_ctrl;
                  main_data_n = skid_data;
               end
            end
            default: next_state = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         ready_q    <= 1'b0;
         in_ready_q <= 1'b0;
         main_ctrl  <= '0;
         main_data  <= '0;
         skid_ctrl  <= '0;
         skid_data  <= '0;
      end else begin
         state      <= next_state;
         ready_q    <= 1'b1;
         in_ready_q <= (next_state != TWO);
         main_ctrl  <= main_ctrl_n;
         main_data  <= main_data_n;
         skid_ctrl  <= skid_ctrl_n;
         skid_data  <= skid_data_n;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.out_ctrl  = out_valid_w ? main_ctrl : '0;
   assign bus.out_data  = main_data;
   assign state_dbg     = state;

   sat_counter #(.W(CNT_W)) u_stall (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid_w && !bus.out_ready),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_bubble (
      .clk   (clk),
      .reset (reset),
      .inc   (!out_valid_w),
      .count (bubble_count)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid-buffered stage and a single-entry stage with 4-bit counters,
// each tracked by a bounded FIFO model with its own expected queue and counter model.
module tb_pipe_stage_reg;
   import pipe_pkg::*;

   localparam int CTRL_W = ID_EX_CTRL_W;
   localparam int DATA_W = ID_EX_DATA_W;
   localparam int BW     = CTRL_W + DATA_W;
   localparam int MAX1   = 65535;
   localparam int MAX0   = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush1 = 1'b0;
   logic        flush0 = 1'b0;
   logic [15:0] stall1, bubble1;
   logic [3:0]  stall0, bubble0;
   pipe_state_e st1, st0;

   int checks = 0;
   int errors = 0;

   logic [BW-1:0]     exp_q1[$];
   logic [BW-1:0]     exp_q0[$];
   logic [DATA_W-1:0] last_m[2];
   logic              rdy_m[2];
   int                stall_m[2];
   int                bubble_m[2];

   pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) b1();
   pipe_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) b0();

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1),
                    .CLEAR_DATA_ON_FLUSH(0), .CNT_W(16)) dut1 (
      .clk(clk), .reset(reset), .bus(b1), .flush(flush1),
      .stall_count(stall1), .bubble_count(bubble1), .state_dbg(st1)
   );

   pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0),
                    .CLEAR_DATA_ON_FLUSH(0), .CNT_W(4)) dut0 (
      .clk(clk), .reset(reset), .bus(b0), .flush(flush0),
      .stall_count(stall0), .bubble_count(bubble0), .state_dbg(st0)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checker ----------------
   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitors (sample on falling edge) ----------------
   always @(negedge clk) begin : mon1
      logic [BW-1:0] exp_b;
      logic          rdy_e, ifire, ofire;
      if (reset) begin
         chk("rst_out_valid1", BW'(b1.out_valid), '0);
         chk("rst_in_ready1",  BW'(b1.in_ready), '0);
         chk("rst_bundle1",    {b1.out_ctrl, b1.out_data}, '0);
         chk("rst_stall1",     BW'(stall1), '0);
         chk("rst_bubble1",    BW'(bubble1), '0);
         exp_q1.delete();
         last_m[1] = '0; rdy_m[1] = 1'b0; stall_m[1] = 0; bubble_m[1] = 0;
      end else begin
         rdy_e = rdy_m[1] && (exp_q1.size() < 2);
         exp_b = (exp_q1.size() > 0) ? exp_q1[0] : {CTRL_W'(0), last_m[1]};
         chk("out_valid1", BW'(b1.out_valid), BW'(exp_q1.size() > 0));
         chk("in_ready1",  BW'(b1.in_ready), BW'(rdy_e));
         chk("bundle1",    {b1.out_ctrl, b1.out_data}, exp_b);
         chk("stall1",     BW'(stall1), BW'(stall_m[1]));
         chk("bubble1",    BW'(bubble1), BW'(bubble_m[1]));
         if (exp_q1.size() > 0) begin
            last_m[1] = exp_q1[0][DATA_W-1:0];
            if (!b1.out_ready && stall_m[1] < MAX1) stall_m[1]++;
         end else if (bubble_m[1] < MAX1) begin
            bubble_m[1]++;
         end
         ofire = (exp_q1.size() > 0) && b1.out_ready;
         ifire = rdy_e && b1.in_valid;
         if (flush1) begin
            exp_q1.delete();
         end else begin
            if (ofire) void'(exp_q1.pop_front());
            if (ifire) exp_q1.push_back({b1.in_ctrl, b1.in_data});
         end
         rdy_m[1] = 1'b1;
      end
   end

   always @(negedge clk) begin : mon0
      logic [BW-1:0] exp_b;
      logic          rdy_e, ifire, ofire;
      if (reset) begin
         chk("rst_out_valid0", BW'(b0.out_valid), '0);
         chk("rst_in_ready0",  BW'(b0.in_ready), '0);
         chk("rst_bundle0",    {b0.out_ctrl, b0.out_data}, '0);
         chk("rst_stall0",     BW'(stall0), '0);
         chk("rst_bubble0",    BW'(bubble0), '0);
         exp_q0.delete();
         last_m[0] = '0; rdy_m[0] = 1'b0; stall_m[0] = 0; bubble_m[0] = 0;
      end else begin
         rdy_e = rdy_m[0] && ((exp_q0.size() == 0) || b0.out_ready);
         exp_b = (exp_q0.size() > 0) ? exp_q0[0] : {CTRL_W'(0), last_m[0]};
         chk("out_valid0", BW'(b0.out_valid), BW'(exp_q0.size() > 0));
         chk("in_ready0",  BW'(b0.in_ready), BW'(rdy_e));
         chk("bundle0",    {b0.out_ctrl, b0.out_data}, exp_b);
         chk("stall0",     BW'(stall0), BW'(stall_m[0]));
         chk("bubble0",    BW'(bubble0), BW'(bubble_m[0]));
         if (exp_q0.size() > 0) begin
            last_m[0] = exp_q0[0][DATA_W-1:0];
            if (!b0.out_ready && stall_m[0] < MAX0) stall_m[0]++;
         end else if (bubble_m[0] < MAX0) begin
            bubble_m[0]++;
         end
         ofire = (exp_q0.size() > 0) && b0.out_ready;
         ifire = rdy_e && b0.in_valid;
         if (flush0) begin
            exp_q0.delete();
         end else begin
            if (ofire) void'(exp_q0.pop_front());
            if (ifire) exp_q0.push_back({b0.in_ctrl, b0.in_data});
         end
         rdy_m[0] = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rnd_data();
      return DATA_W'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   // Offer one item to the skid stage and hold it until accepted; out_ready rises at release_at.
   task automatic send1(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input int release_at);
      logic acc = 1'b0;
      b1.in_valid = 1'b1;
      b1.in_ctrl  = c;
      b1.in_data  = d;
      for (int k = 0; k < 20 && !acc; k++) begin
         if (k == release_at) b1.out_ready = 1'b1;
         @(negedge clk);
         acc = b1.in_ready;
         tick();
      end
      b1.in_valid = 1'b0;
      chk("send1_accept", BW'(acc), BW'(1));
   endtask

   task automatic rand_cycles(input int n, input bit do1, input bit do0);
      for (int i = 0; i < n; i++) begin
         if (do1) begin
            b1.in_valid  = ($urandom_range(0, 3) != 0);
            b1.in_ctrl   = CTRL_W'($urandom);
            b1.in_data   = rnd_data();
            b1.out_ready = ($urandom_range(0, 2) != 0);
            flush1       = ($urandom_range(0, 31) == 0);
         end
         if (do0) begin
            b0.in_valid  = ($urandom_range(0, 3) != 0);
            b0.in_ctrl   = CTRL_W'($urandom);
            b0.in_data   = rnd_data();
            b0.out_ready = ($urandom_range(0, 2) != 0);
            flush0       = ($urandom_range(0, 31) == 0);
         end
         tick();
      end
      flush1 = 1'b0;
      flush0 = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      b1.in_valid = 1'b0; b1.in_ctrl = '0; b1.in_data = '0; b1.out_ready = 1'b0;
      b0.in_valid = 1'b0; b0.in_ctrl = '0; b0.in_data = '0; b0.out_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // idle long enough to saturate the 4-bit bubble counter
      repeat (20) tick();

      // streaming through the skid stage
      b1.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b1.in_valid = 1'b1;
         b1.in_ctrl  = CTRL_W'($urandom);
         b1.in_data  = DATA_W'(i);
         tick();
      end
      b1.in_valid = 1'b0;
      repeat (2) tick();

      // backpressure: A held, B in skid, C waits for release
      b1.out_ready = 1'b0;
      send1(CTRL_W'($urandom), DATA_W'(32'hA), -1);
      send1(CTRL_W'($urandom), DATA_W'(32'hB), -1);
      send1(CTRL_W'($urandom), DATA_W'(32'hC), 3);
      repeat (4) tick();

      // flush from the two-entry state with an input offered
      b1.out_ready = 1'b0;
      send1('1, DATA_W'(32'h1111), -1);
      send1('1, DATA_W'(32'h2222), -1);
      b1.in_valid = 1'b1;
      b1.in_ctrl  = '1;
      b1.in_data  = DATA_W'(32'h3333);
      flush1      = 1'b1;
      tick();
      flush1      = 1'b0;
      b1.in_valid = 1'b0;
      repeat (2) tick();

      rand_cycles(300, 1'b1, 1'b0);
      b1.in_valid = 1'b0;

      // single-entry stage: in_ready follows out_ready in the same cycle
      for (int i = 0; i < 6; i++) begin
         b0.in_valid  = 1'b1;
         b0.in_ctrl   = CTRL_W'($urandom);
         b0.in_data   = DATA_W'(100 + i);
         b0.out_ready = (i != 2) && (i != 4);
         tick();
      end
      b0.in_valid = 1'b0;
      rand_cycles(300, 1'b0, 1'b1);

      // asynchronous reset in the middle of traffic
      rand_cycles(10, 1'b1, 1'b1);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_valid1", BW'(b1.out_valid), '0);
      chk("async_rst_valid0", BW'(b0.out_valid), '0);
      chk("async_rst_ready1", BW'(b1.in_ready), '0);
      chk("async_rst_ready0", BW'(b0.in_ready), '0);
      chk("async_rst_bundle1", {b1.out_ctrl, b1.out_data}, '0);
      chk("async_rst_bundle0", {b0.out_ctrl, b0.out_data}, '0);
      chk("async_rst_cnt1", BW'({stall1, bubble1}), '0);
      chk("async_rst_cnt0", BW'({stall0, bubble0}), '0);
      @(posedge clk);
      #1 reset = 1'b0;
      rand_cycles(40, 1'b1, 1'b1);

      b1.in_valid = 1'b0; b1.out_ready = 1'b1;
      b0.in_valid = 1'b0; b0.out_ready = 1'b1;
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
